// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared definitions for the 7-segment display scan logic:
//               digit count, index width, scan FSM encoding and the
//               hex-to-7-segment decode function (segments g..a, bit0 = a).
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int c_num_digits = 6;
    localparam int c_idx_w      = 3;

    // Scan FSM encoding. GUARD blanks the bus, DRIVE lights one digit.
    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Active-high segment pattern for one hex code, bit0 = segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_tick.sv
`default_nettype none
// ============================================================================
// Module      : nco_tick
// Description : Phase-accumulator NCO. Each clock adds i_nco_num to the
//               accumulator; the carry out is registered as o_tick.
//               o_tick_nxt is the carry being computed this cycle, i.e. the
//               value o_tick will take after the next edge, for consumers
//               that must act one cycle ahead of the tick.
// Ports       : clk        - system clock
//               rst        - asynchronous active-high reset
//               i_nco_num  - phase increment (0 = no ticks)
//               o_tick     - registered carry pulse
//               o_tick_nxt - look-ahead of o_tick (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module nco_tick #(
    parameter int NCO_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCO_W-1:0] i_nco_num,
    output logic             o_tick,
    output logic             o_tick_nxt
);

    logic [NCO_W-1:0] r_acc;
    logic [NCO_W-1:0] w_sum;
    logic             w_carry;

    assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, i_nco_num};
    assign o_tick_nxt       = w_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            o_tick <= 1'b0;
        end else begin
            r_acc  <= w_sum;
            o_tick <= w_carry;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for a 6-digit 7-segment
//               display. An NCO paces the per-digit dwell; a GUARD state
//               blanks every enable between digits. New digit data is
//               staged in pending registers and copied to the shadow
//               (displayed) registers only at the frame boundary, so a
//               frame never tears.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               i_nco_num    - NCO increment (dwell rate)
//               i_load       - strobe qualifying i_digits/i_dp/i_blank
//               i_digits     - six 4-bit hex codes, digit n = [4n+3:4n]
//               i_dp, i_blank- per-digit decimal point / blank masks
//               o_seg        - segments g..a, active-high
//               o_seg_enb    - one-hot digit enable
//               o_seg_dp     - decimal point
//               o_pend       - load captured, not yet applied
//               o_frame      - high during the cycle that leaves digit 5
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NCO_W     = 32,
    parameter int GUARD_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCO_W-1:0] i_nco_num,
    input  logic             i_load,
    input  logic [23:0]      i_digits,
    input  logic [5:0]       i_dp,
    input  logic [5:0]       i_blank,
    output logic [6:0]       o_seg,
    output logic [5:0]       o_seg_enb,
    output logic             o_seg_dp,
    output logic             o_pend,
    output logic             o_frame
);

    localparam int                 c_gcnt_w     = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [c_gcnt_w-1:0] c_guard_last = c_gcnt_w'(GUARD_CYC - 1);
    localparam logic [c_idx_w-1:0]  c_last_idx   = c_idx_w'(c_num_digits - 1);
    localparam logic [c_num_digits-1:0] c_enb_one = {{(c_num_digits-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Dwell NCO
    // ------------------------------------------------------------------
    logic w_tick;
    logic w_tick_nxt;

    nco_tick #(
        .NCO_W (NCO_W)
    ) u_nco_tick (
        .clk        (clk),
        .rst        (rst),
        .i_nco_num  (i_nco_num),
        .o_tick     (w_tick),
        .o_tick_nxt (w_tick_nxt)
    );

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    scan_state_t         r_state;
    scan_state_t         w_state_nxt;
    logic [c_gcnt_w-1:0] r_gcnt;
    logic [c_gcnt_w-1:0] w_gcnt_nxt;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  w_idx_nxt;
    logic                r_tick_pend;
    logic                w_tick_pend_nxt;
    logic                w_exit;
    logic                w_boundary;
    logic                w_frame_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_GUARD;
            r_gcnt      <= '0;
            r_idx       <= '0;
            r_tick_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_idx       <= w_idx_nxt;
            r_tick_pend <= w_tick_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gcnt_nxt      = r_gcnt;
        w_idx_nxt       = r_idx;
        w_tick_pend_nxt = r_tick_pend;
        w_exit          = 1'b0;
        case (r_state)
            ST_GUARD: begin
                // One-deep memory: a tick during the guard shortens the
                // following DRIVE to a single cycle; extra ticks are dropped.
                if (w_tick) begin
                    w_tick_pend_nxt = 1'b1;
                end
                if (r_gcnt == c_guard_last) begin
                    w_gcnt_nxt  = '0;
                    w_state_nxt = ST_DRIVE;
                end else begin
                    w_gcnt_nxt = r_gcnt + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (w_tick || r_tick_pend) begin
                    w_exit          = 1'b1;
                    w_tick_pend_nxt = 1'b0;
                    w_state_nxt     = ST_GUARD;
                    w_idx_nxt       = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_GUARD;
            end
        endcase
    end

    assign w_boundary = w_exit && (r_idx == c_last_idx);

    // o_frame is registered yet must be high in the boundary cycle itself,
    // so predict next cycle's exit from the NCO look-ahead carry and the
    // next value of the pending-tick flag.
    assign w_frame_nxt = (w_state_nxt == ST_DRIVE) && (w_idx_nxt == c_last_idx)
                         && (w_tick_nxt || w_tick_pend_nxt);

    // ------------------------------------------------------------------
    // Load path: pending registers and displayed shadow
    // ------------------------------------------------------------------
    logic [c_num_digits-1:0][3:0] r_sh_digits;
    logic [c_num_digits-1:0]      r_sh_dp;
    logic [c_num_digits-1:0]      r_sh_blank;
    logic [c_num_digits-1:0][3:0] r_pd_digits;
    logic [c_num_digits-1:0]      r_pd_dp;
    logic [c_num_digits-1:0]      r_pd_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '1;
            r_pd_digits <= '0;
            r_pd_dp     <= '0;
            r_pd_blank  <= '0;
            o_pend      <= 1'b0;
        end else if (w_boundary) begin
            // A load landing exactly on the boundary goes straight to the
            // shadow and never shows up as pending.
            if (i_load) begin
                r_sh_digits <= i_digits;
                r_sh_dp     <= i_dp;
                r_sh_blank  <= i_blank;
            end else if (o_pend) begin
                r_sh_digits <= r_pd_digits;
                r_sh_dp     <= r_pd_dp;
                r_sh_blank  <= r_pd_blank;
            end
            o_pend <= 1'b0;
        end else if (i_load) begin
            r_pd_digits <= i_digits;
            r_pd_dp     <= i_dp;
            r_pd_blank  <= i_blank;
            o_pend      <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output registers: decoded from the state being entered so that the
    // registered outputs line up with the FSM state cycle for cycle.
    // ------------------------------------------------------------------
    logic [6:0]              w_seg_nxt;
    logic [c_num_digits-1:0] w_enb_nxt;
    logic                    w_dp_nxt;

    always_comb begin
        w_seg_nxt = '0;
        w_enb_nxt = '0;
        w_dp_nxt  = 1'b0;
        if (w_state_nxt == ST_DRIVE) begin
            w_enb_nxt = c_enb_one << w_idx_nxt;
            if (!r_sh_blank[w_idx_nxt]) begin
                w_seg_nxt = hex_to_seg(r_sh_digits[w_idx_nxt]);
                w_dp_nxt  = r_sh_dp[w_idx_nxt];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_seg     <= '0;
            o_seg_enb <= '0;
            o_seg_dp  <= 1'b0;
            o_frame   <= 1'b0;
        end else begin
            o_seg     <= w_seg_nxt;
            o_seg_enb <= w_enb_nxt;
            o_seg_dp  <= w_dp_nxt;
            o_frame   <= w_frame_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed self-checking bench for seg_scan_ctrl. One
//               instance uses GUARD_CYC = 2 with a P = 10 NCO; a second
//               instance uses GUARD_CYC = 4 with a P = 2 NCO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] r_nco_num;
    logic [31:0] r_fast_nco;
    logic        r_load;
    logic [23:0] r_digits;
    logic [5:0]  r_dp;
    logic [5:0]  r_blank;

    logic [6:0]  w_seg;
    logic [5:0]  w_enb;
    logic        w_dp;
    logic        w_pend;
    logic        w_frame;

    logic [6:0]  w_f_seg;
    logic [5:0]  w_f_enb;
    logic        w_f_dp;
    logic        w_f_pend;
    logic        w_f_frame;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scan_ctrl #(.NCO_W(32), .GUARD_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_nco_num (r_nco_num),
        .i_load    (r_load),
        .i_digits  (r_digits),
        .i_dp      (r_dp),
        .i_blank   (r_blank),
        .o_seg     (w_seg),
        .o_seg_enb (w_enb),
        .o_seg_dp  (w_dp),
        .o_pend    (w_pend),
        .o_frame   (w_frame)
    );

    seg_scan_ctrl #(.NCO_W(32), .GUARD_CYC(4)) dut_fast (
        .clk       (clk),
        .rst       (rst),
        .i_nco_num (r_fast_nco),
        .i_load    (r_load),
        .i_digits  (r_digits),
        .i_dp      (r_dp),
        .i_blank   (r_blank),
        .o_seg     (w_f_seg),
        .o_seg_enb (w_f_enb),
        .o_seg_dp  (w_f_dp),
        .o_pend    (w_f_pend),
        .o_frame   (w_f_frame)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    // Reset, then the dark walk with P = 10, guard 2.
    task automatic test_reset();
        logic [5:0] one;
        logic [5:0] exp_enb;
        int bad_enb, bad_frame, bad_seg, d, ph;
        one = 6'b000001;
        bad_enb = 0; bad_frame = 0; bad_seg = 0;
        rst = 1'b1;
        r_nco_num = 32'd429496730;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({w_seg, w_enb, w_dp, w_pend, w_frame} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0000", {w_seg, w_enb, w_dp, w_pend, w_frame});
        end
        n_checks++;
        if ({w_f_seg, w_f_enb, w_f_dp, w_f_pend, w_f_frame} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs_fast: got %h, want 0000", {w_f_seg, w_f_enb, w_f_dp, w_f_pend, w_f_frame});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (w_enb !== 6'h00) begin
            n_fail++;
            $display("FAIL first_guard: enb got %h, want 00", w_enb);
        end
        @(negedge clk);
        n_checks++;
        if (w_enb !== 6'h01) begin
            n_fail++;
            $display("FAIL first_drive: enb got %h, want 01", w_enb);
        end
        // Digit 1 starts 11 cycles later; steady-state 10-cycle period from there.
        repeat (11) @(negedge clk);
        for (int k = 0; k < 120; k++) begin
            if (k > 0) @(negedge clk);
            d  = (1 + k / 10) % 6;
            ph = k % 10;
            exp_enb = (ph < 8) ? (one << d) : 6'h00;
            if (w_enb !== exp_enb) bad_enb++;
            if (w_frame !== ((d == 5) && (ph == 7))) bad_frame++;
            if (w_seg !== 7'h00 || w_dp !== 1'b0) bad_seg++;
        end
        n_checks++;
        if (bad_enb !== 0) begin
            n_fail++;
            $display("FAIL dark_walk_enb: %0d bad cycles, want 0", bad_enb);
        end
        n_checks++;
        if (bad_frame !== 0) begin
            n_fail++;
            $display("FAIL dark_walk_frame: %0d bad cycles, want 0", bad_frame);
        end
        n_checks++;
        if (bad_seg !== 0) begin
            n_fail++;
            $display("FAIL dark_walk_seg: %0d lit cycles, want 0", bad_seg);
        end
    endtask

    // Mid-frame load is held pending and applied at the boundary.
    task automatic test_load_at_frame();
        int bad_pend;
        bad_pend = 0;
        for (int i = 0; i < 200; i++) begin
            if (w_enb === 6'h04) break;
            @(negedge clk);
        end
        n_checks++;
        if (w_enb !== 6'h04) begin
            n_fail++;
            $display("FAIL load_wait_digit2: enb got %h, want 04", w_enb);
        end
        r_load = 1'b1; r_digits = 24'h123456; r_dp = 6'b000100; r_blank = 6'h00;
        @(negedge clk);
        r_load = 1'b0;
        n_checks++;
        if (w_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL load_pend_rise: pend got %b, want 1", w_pend);
        end
        for (int i = 0; i < 100; i++) begin
            if (w_frame === 1'b1) break;
            if (w_pend !== 1'b1) bad_pend++;
            @(negedge clk);
        end
        n_checks++;
        if (w_frame !== 1'b1 || bad_pend !== 0) begin
            n_fail++;
            $display("FAIL load_pend_hold: frame got %b want 1, pend drops %0d want 0", w_frame, bad_pend);
        end
        @(negedge clk);
        n_checks++;
        if (w_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL load_pend_clear: pend got %b, want 0", w_pend);
        end
        @(negedge clk);
        n_checks++;
        if (w_enb !== 6'h00) begin
            n_fail++;
            $display("FAIL load_guard: enb got %h, want 00", w_enb);
        end
        @(negedge clk);
        n_checks++;
        if ({w_enb, w_seg, w_dp} !== {6'h01, 7'h7D, 1'b0}) begin
            n_fail++;
            $display("FAIL load_digit0: enb/seg/dp got %h/%h/%b, want 01/7d/0", w_enb, w_seg, w_dp);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if ({w_enb, w_seg, w_dp} !== {6'h02, 7'h6D, 1'b0}) begin
            n_fail++;
            $display("FAIL load_digit1: enb/seg/dp got %h/%h/%b, want 02/6d/0", w_enb, w_seg, w_dp);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if ({w_enb, w_seg, w_dp} !== {6'h04, 7'h66, 1'b1}) begin
            n_fail++;
            $display("FAIL load_digit2: enb/seg/dp got %h/%h/%b, want 04/66/1", w_enb, w_seg, w_dp);
        end
    endtask

    // Two loads in one frame (last wins), then a load on the boundary cycle.
    task automatic test_back_to_back();
        int bad_seg, drives, bad_pend;
        bad_seg = 0; drives = 0; bad_pend = 0;
        for (int i = 0; i < 100; i++) begin
            if (w_frame === 1'b1) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        r_load = 1'b1; r_digits = 24'h111111; r_dp = 6'h00; r_blank = 6'h00;
        @(negedge clk);
        r_load = 1'b0;
        repeat (10) @(negedge clk);
        r_load = 1'b1; r_digits = 24'h222222;
        @(negedge clk);
        r_load = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (w_frame === 1'b1) break;
            @(negedge clk);
        end
        n_checks++;
        if (w_frame !== 1'b1 || w_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL lastwins_boundary: frame/pend got %b/%b, want 1/1", w_frame, w_pend);
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (w_enb !== 6'h00) begin
                drives++;
                if (w_seg !== 7'h5B) bad_seg++;
            end
        end
        n_checks++;
        if (bad_seg !== 0 || drives !== 48) begin
            n_fail++;
            $display("FAIL lastwins_seg: wrong-seg cycles %0d want 0, drive cycles %0d want 48", bad_seg, drives);
        end
        n_checks++;
        if (w_frame !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_period: frame got %b 60 cycles later, want 1", w_frame);
        end
        r_load = 1'b1; r_digits = 24'h333333;
        @(negedge clk);
        r_load = 1'b0;
        n_checks++;
        if (w_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_pend: pend got %b, want 0", w_pend);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({w_enb, w_seg} !== {6'h01, 7'h4F}) begin
            n_fail++;
            $display("FAIL bypass_digit0: enb/seg got %h/%h, want 01/4f", w_enb, w_seg);
        end
        for (int k = 0; k < 56; k++) begin
            @(negedge clk);
            if (w_pend !== 1'b0) bad_pend++;
        end
        n_checks++;
        if (bad_pend !== 0) begin
            n_fail++;
            $display("FAIL bypass_pend_hold: pend high %0d cycles, want 0", bad_pend);
        end
    endtask

    // Asynchronous reset during DRIVE of digit 3 with a load pending.
    task automatic test_async_reset();
        int bad_dark, drives;
        bad_dark = 0; drives = 0;
        for (int i = 0; i < 150; i++) begin
            if (w_enb === 6'h08) break;
            @(negedge clk);
        end
        r_load = 1'b1; r_digits = 24'h999999;
        @(negedge clk);
        r_load = 1'b0;
        n_checks++;
        if ({w_enb, w_seg, w_pend} !== {6'h08, 7'h4F, 1'b1}) begin
            n_fail++;
            $display("FAIL arst_pre: enb/seg/pend got %h/%h/%b, want 08/4f/1", w_enb, w_seg, w_pend);
        end
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({w_seg, w_enb, w_dp, w_pend, w_frame} !== 16'h0000) begin
            n_fail++;
            $display("FAIL arst_clear: outputs got %h, want 0000", {w_seg, w_enb, w_dp, w_pend, w_frame});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (w_enb !== 6'h00) drives++;
            if (w_seg !== 7'h00 || w_dp !== 1'b0 || w_pend !== 1'b0) bad_dark++;
        end
        n_checks++;
        if (bad_dark !== 0 || drives == 0) begin
            n_fail++;
            $display("FAIL arst_dark: lit/pend cycles %0d want 0, drive cycles %0d want >0", bad_dark, drives);
        end
    endtask

    // i_nco_num = 0 parks the scan on digit 0.
    task automatic test_zero_increment();
        int bad_hold;
        bad_hold = 0;
        @(negedge clk);
        r_nco_num = 32'd0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        r_load = 1'b1; r_digits = 24'h777777;
        @(negedge clk);
        r_load = 1'b0;
        n_checks++;
        if ({w_enb, w_pend} !== {6'h01, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_first: enb/pend got %h/%b, want 01/1", w_enb, w_pend);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (w_enb !== 6'h01 || w_seg !== 7'h00 || w_pend !== 1'b1 || w_frame !== 1'b0) bad_hold++;
        end
        n_checks++;
        if (bad_hold !== 0) begin
            n_fail++;
            $display("FAIL zero_hold: %0d cycles off digit 0 or lit, want 0", bad_hold);
        end
    endtask

    // P = 2 with guard 4: every DRIVE lasts one cycle via the pending tick.
    task automatic test_fast_nco();
        int bad_hot, bad_drive, bad_guard, bad_seq, drives, run_len;
        logic prev_nz, nz;
        logic [5:0] last;
        bad_hot = 0; bad_drive = 0; bad_guard = 0; bad_seq = 0; drives = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (w_f_enb !== 6'h00) break;
            @(negedge clk);
        end
        n_checks++;
        if (w_f_enb !== 6'h01) begin
            n_fail++;
            $display("FAIL fast_first: enb got %h, want 01", w_f_enb);
        end
        last = w_f_enb; prev_nz = 1'b1; run_len = 1;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            nz = (w_f_enb !== 6'h00);
            if ($countones(w_f_enb) > 1) bad_hot++;
            if (nz == prev_nz) begin
                run_len++;
            end else begin
                if (prev_nz && run_len != 1) bad_drive++;
                if (!prev_nz && run_len != 4) bad_guard++;
                if (nz) begin
                    if (w_f_enb !== {last[4:0], last[5]}) bad_seq++;
                    last = w_f_enb;
                    drives++;
                end
                run_len = 1;
                prev_nz = nz;
            end
        end
        n_checks++;
        if (bad_hot !== 0) begin
            n_fail++;
            $display("FAIL fast_onehot: %0d multi-bit cycles, want 0", bad_hot);
        end
        n_checks++;
        if (bad_drive !== 0 || bad_guard !== 0) begin
            n_fail++;
            $display("FAIL fast_runs: drive runs !=1 %0d, guard runs !=4 %0d, want 0/0", bad_drive, bad_guard);
        end
        n_checks++;
        if (bad_seq !== 0 || drives !== 30) begin
            n_fail++;
            $display("FAIL fast_sequence: order errors %0d want 0, drives %0d want 30", bad_seq, drives);
        end
    endtask

    initial begin
        rst        = 1'b1;
        r_nco_num  = 32'd429496730;
        r_fast_nco = 32'h8000_0000;
        r_load     = 1'b0;
        r_digits   = 24'h0;
        r_dp       = 6'h00;
        r_blank    = 6'h00;
        test_reset();
        test_load_at_frame();
        test_back_to_back();
        test_async_reset();
        test_zero_increment();
        test_fast_nco();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the shared 6-digit 7-segment display bus (`o_seg`, `o_seg_enb`, `o_seg_dp`) on the 50 MHz board clock. An internal NCO sets the per-digit dwell rate, and a guard state blanks all enables between digits to prevent ghosting. A load handshake takes new digit data from the counter datapath and applies it only at frame boundaries, so a displayed frame never tears.

## Interface
- `NCO_W`, 32: phase accumulator width.
- `GUARD_CYC`, 4: blank clocks between digits, ≥1.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `i_nco_num` in NCO_W: NCO increment. Digit tick rate = `i_nco_num`·f_clk/2^NCO_W.
- `i_load` in 1: one-cycle strobe; qualifies `i_digits`/`i_dp`/`i_blank`.
- `i_digits` in 24: six 4-bit hex codes; digit n = bits [4n+3:4n].
- `i_dp` in 6: decimal-point mask; bit n = digit n.
- `i_blank` in 6: digit blank mask; 1 forces segments off for that digit.
- `o_seg` out 7: segments g..a, active-high, bit0 = a.
- `o_seg_enb` out 6: digit enables, one-hot active-high, bit n = digit n.
- `o_seg_dp` out 1: decimal point, active-high.
- `o_pend` out 1: load captured, not yet applied.
- `o_frame` out 1: one-cycle pulse when leaving digit 5.

## Operation
- NCO: `acc <= acc + i_nco_num`. The carry out, registered, is `tick`. `i_nco_num` = 0 produces no ticks.
- FSM states:
  - GUARD: enables, segments and dp all 0. Runs GUARD_CYC clocks, then goes to DRIVE.
  - DRIVE: `o_seg_enb[idx]` = 1. `o_seg` = hex decode of shadow digit idx, or 0 if shadow blank[idx]. `o_seg_dp` = shadow dp[idx] & ~blank[idx]. On `tick` or `tick_pend`: idx ← idx+1 (5 wraps to 0), clear `tick_pend`, go to GUARD.
- A tick arriving in GUARD sets the one-deep `tick_pend`. Further ticks in the same GUARD are dropped.
- Hex decode 0–F, segments a..g:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
- Load path:
  - `i_load` copies the inputs into the pending registers and sets `o_pend`. A second load while pending overwrites it (last wins).
  - Frame boundary = DRIVE-exit cycle with idx = 5. On it, `o_frame` = 1 and, if `o_pend` or `i_load`, shadow ← (`i_load` ? inputs : pending) and `o_pend` clears.
  - `i_load` in the boundary cycle bypasses straight into the shadow; `o_pend` stays 0.
- Reset values:
  - acc = 0, tick = 0, `tick_pend` = 0.
  - state GUARD with guard counter 0, idx = 0.
  - shadow: digits 0, dp 0, blank all 1 (display dark until first load).
  - pending registers 0.
  - all outputs 0.
- Reset mid-frame: asynchronous clear to the above. Any pending load is lost.

## Timing
- All outputs are registered. `o_seg`, `o_seg_enb` and `o_seg_dp` change in the same cycle.
- Guard length is exactly GUARD_CYC cycles with `o_seg_enb` = 0.
- With tick period P > GUARD_CYC+1: DRIVE lasts P−GUARD_CYC cycles. One frame = 6·P.
- With P ≤ GUARD_CYC+1: DRIVE lasts 1 cycle via `tick_pend`.
- `o_pend` rises the cycle after `i_load`.
- A new shadow value shows on the first DRIVE of digit 0 after the boundary, GUARD_CYC+1 cycles after `o_frame`.
- Never more than one `o_seg_enb` bit set. `o_seg_enb` is never nonzero during GUARD.

## Structure
- Shared package `seg_pkg`: digit count (6), hex-to-7seg decode function, FSM state encoding (GUARD, DRIVE).
- One sub-module, `nco_tick`: accumulator plus registered carry, parameterised on NCO_W. It is reused by the counter datapath.
- FSM, load/shadow registers and output registers stay in `seg_scan_ctrl`.

## Test plan
- Reset dark:
  - Stimulus: `rst` = 1, then release; `i_nco_num` = 429496730 (P = 10), GUARD_CYC = 2, no load.
  - Response: `o_seg_enb` walks 01, 02, 04 … 20 with 8-cycle dwell and 2-cycle zero gaps; `o_seg` = 0; `o_frame` every 60 cycles.
- Load at frame:
  - Stimulus: `i_load` with `i_digits` = 0x123456, `i_dp` = 6'b000100, `i_blank` = 0, mid-frame.
  - Response: `o_pend` = 1 until `o_frame`; then digit 0 shows 7D (6), digit 2 shows 66 (4) with dp = 1; `o_pend` = 0.
- Last-wins and boundary bypass:
  - Stimulus: two loads (0x111111, then 0x222222) in one frame.
  - Response: only 5B appears.
  - Stimulus: a load of 0x333333 exactly in the `o_frame` cycle.
  - Response: 4F from the next digit 0; `o_pend` never rises.
- Zero increment:
  - Stimulus: `i_nco_num` = 0 after a load.
  - Response: `o_seg_enb` = 01 held indefinitely after the 2-cycle guard.
- Fast NCO:
  - Stimulus: `i_nco_num` = 2^31 (P = 2), GUARD_CYC = 4.
  - Response: each DRIVE lasts exactly 1 cycle; never two enable bits set.
- Async reset mid-DRIVE:
  - Stimulus: assert `rst` mid-DRIVE on digit 3 with a load pending.
  - Response: all outputs 0 in the same cycle without a clock edge; after release, the display is dark and `o_pend` = 0.
